// File: rtl/bram_access_ctrl.sv
// Port-A requester for a byte-enabled BRAM with a 1-cycle registered read.
// Splits byte/half/word accesses into word accesses, taking a second RAM cycle when an access crosses a word boundary.
module bram_access_ctrl #(
  parameter int ADDRESS_BITWIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [1:0]                    req_size,
  input  logic                          req_signed,
  input  logic [ADDRESS_BITWIDTH+1:0]   req_address,
  input  logic [31:0]                   req_data,
  output logic                          rsp_valid,
  output logic [31:0]                   rsp_data,
  output logic [3:0]                    ram_write_enable,
  output logic [ADDRESS_BITWIDTH-1:0]   ram_address,
  output logic [31:0]                   ram_data_in,
  input  logic [31:0]                   ram_data_out
);
  localparam int AW = ADDRESS_BITWIDTH;

  typedef enum logic [2:0] {IDLE, WR2, RD1, RD2, RSP} state_t;
  state_t state, state_nxt;

  logic [AW+1:0] addr_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [31:0]   data_q;
  logic [31:0]   lo_q;

  // Request fields come straight from the port while accepting, else from the captured copy.
  logic          accepting;
  logic          accept;
  logic [AW+1:0] src_addr;
  logic [1:0]    src_size;
  logic [31:0]   src_data;
  logic [1:0]    off;
  logic [AW-1:0] w, w1;
  logic [3:0]    bmask;
  logic [7:0]    m;
  logic [63:0]   d;
  logic          span;

  assign accepting = (state == IDLE) || (state == RSP);
  assign accept    = accepting && req_valid && !rst;
  assign src_addr  = accepting ? req_address : addr_q;
  assign src_size  = accepting ? req_size    : size_q;
  assign src_data  = accepting ? req_data    : data_q;
  assign off       = src_addr[1:0];
  assign w         = src_addr[AW+1:2];
  assign w1        = w + 1'b1;
  assign bmask     = (src_size == 2'b00) ? 4'b0001 :
                     (src_size == 2'b01) ? 4'b0011 : 4'b1111;
  assign m         = {4'b0000, bmask} << off;
  assign d         = {32'b0, src_data} << {off, 3'b000};
  assign span      = |m[7:4];

  always_comb begin
    state_nxt        = state;
    req_ready        = 1'b0;
    ram_write_enable = 4'b0000;
    ram_address      = w;
    ram_data_in      = d[31:0];
    case (state)
      IDLE, RSP: begin
        req_ready = !rst;
        state_nxt = IDLE;
        if (accept) begin
          if (req_write) begin
            ram_write_enable = m[3:0];
            state_nxt        = span ? WR2 : IDLE;
          end else begin
            state_nxt = RD1;
          end
        end
      end
      WR2: begin
        ram_address      = w1;
        ram_data_in      = d[63:32];
        ram_write_enable = rst ? 4'b0000 : m[7:4];
        state_nxt        = IDLE;
      end
      RD1: begin
        ram_address = span ? w1 : w;
        state_nxt   = span ? RD2 : RSP;
      end
      RD2: begin
        ram_address = w1;
        state_nxt   = RSP;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) state_nxt = IDLE;
  end

  assign rsp_valid = (state == RSP) && !rst;

  // Load extract: the low word arrives in RD1, the high word (span only) in RD2.
  logic [31:0] ld_lo, ld_hi, ld_sh, ld_ext;
  assign ld_lo = (state == RD2) ? lo_q : ram_data_out;
  assign ld_hi = (state == RD2) ? ram_data_out : 32'b0;
  assign ld_sh = 32'({ld_hi, ld_lo} >> {addr_q[1:0], 3'b000});

  always_comb begin
    case (size_q)
      2'b00:   ld_ext = {{24{signed_q & ld_sh[7]}},  ld_sh[7:0]};
      2'b01:   ld_ext = {{16{signed_q & ld_sh[15]}}, ld_sh[15:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rsp_data <= 32'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q   <= req_address;
        size_q   <= req_size;
        signed_q <= req_signed;
        data_q   <= req_data;
      end
      if (state == RD1) lo_q <= ram_data_out;
      if ((state == RD1 && !span) || state == RD2) rsp_data <= ld_ext;
    end
  end
endmodule
